mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 4-bit 4:1 channel mux (mux4to1).
- Drives the mux selects s1/s0 round-robin over the enabled channels.
- Waits a settle interval, captures the mux output y, and presents it downstream with a valid/ready handshake, tagged with its channel number.
- Lets a bench or consumer scan all four inputs without driving selects by hand.

Parameters:
- WIDTH, 4: data width of the mux output and captured word.
- DWELL, 2: settle cycles between a select change and the capture; legal range 1..15.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst, input, 1: reset; synchronous, active-high.
- en, input, 1: scan enable.
- ch_mask, input, 4: per-channel enable; bit k enables input ik.
- y_in, input, WIDTH: mux output y, fed back to this block.
- s0, output, 1: mux select LSB.
- s1, output, 1: mux select MSB.
- data_out, output, WIDTH: captured sample.
- ch_out, output, 2: channel index of data_out, {s1,s0} at capture.
- valid_out, output, 1: data_out/ch_out valid.
- ready_in, input, 1: downstream accepts when high together with valid_out.
- busy, output, 1: high in SETTLE or HOLD.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - s1=0, s0=0, data_out=0, ch_out=0, valid_out=0, busy=0.
  - Internal last-channel pointer goes to 3, so the first scan starts at channel 0.
  - Dwell counter goes to 0.
  - Reset mid-operation discards any pending sample; valid_out drops on that edge.
- Next-channel function: search (last+1) mod 4, (last+2) mod 4, (last+3) mod 4, last, in that order; take the first index with ch_mask bit set. With a single enabled bit, the same channel repeats. ch_mask is sampled only at a selection edge.
- IDLE:
  - If en=1 and ch_mask!=0: on the next edge set {s1,s0}=next channel, update the pointer, load counter=DWELL, go to SETTLE.
  - Otherwise stay in IDLE; selects hold their last value.
  - ch_mask=0 with en=1 stays in IDLE and never asserts valid_out.
- SETTLE:
  - Counter decrements each edge.
  - On the edge where the counter is 1: data_out<=y_in, ch_out<={s1,s0}, valid_out<=1, go to HOLD.
  - Sample latency: y_in is captured at the DWELL-th edge after the edge that changed the selects.
  - If en=0 at any SETTLE edge: go to IDLE with no capture; the pointer keeps the aborted channel.
- HOLD:
  - valid_out stays 1; data_out and ch_out stay stable until accepted.
  - A transfer happens at an edge with valid_out=1 and ready_in=1.
  - On transfer with en=1 and ch_mask!=0: on the same edge, valid_out<=0, select the next channel, load the counter, go to SETTLE. This gives back-to-back scanning with no IDLE cycle.
  - On transfer otherwise: valid_out<=0 and go to IDLE.
  - en dropping in HOLD does not withdraw valid_out; the held sample must still be accepted.
- Selects never change while in SETTLE or HOLD.
- Peak throughput: one sample per DWELL+1 cycles with ready_in tied high.
- busy = (state != IDLE).

Decomposition:
- Shared package mux_scan_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_HOLD=2'd2;
  - NUM_CH=4;
  - default widths.
- One natural sub-module: rr_next_ch. It is combinational: inputs last[1:0] and mask[3:0]; outputs next[1:0] and any. It is reused by later wider scanners.

Test Plan:
Bench instantiates mux4to1 with i0=1, i1=2, i2=2, i3=3, selects wired from this block and y fed back to y_in; DWELL=2; ready_in=1.
1. Full scan: rst 2 cycles, then en=1, ch_mask=4'b1111 -> (ch_out,data_out) sequence (0,1),(1,2),(2,2),(3,3),(0,1); valid_out pulses every 3 cycles; first valid appears 3 edges after en is sampled.
2. Sparse mask: ch_mask=4'b1010 -> ch_out alternates 1,3,1,3 with data 2,3,2,3; channels 0 and 2 never selected.
3. Backpressure: ready_in=0 for 5 cycles after the first valid -> valid_out, data_out=1, ch_out=0 stay stable; s1/s0 unchanged; next channel is selected only on the edge where ready_in returns to 1.
4. Abort and empty mask: en=0 one cycle into SETTLE -> return to IDLE, no valid. Then ch_mask=0 with en=1 for 10 cycles -> busy=0, valid_out=0 throughout.
5. Reset mid-HOLD: assert rst while valid_out=1 -> next edge gives valid_out=0, data_out=0, s1s0=00. After release with en=1, the first sample is from channel 0.
6. DWELL=1 build: mask 4'b1111, ready_in=1 -> one valid every 2 cycles, correct data per channel.

Source files
------------

// File: rtl/mux_scan_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux scan controller family.
//   scan_state_t : controller state encoding (IDLE / SETTLE / HOLD)
//   NUM_CH       : number of mux inputs scanned
//   CH_W         : width of a channel index
//   DEF_WIDTH    : default data width of the scanned mux
//   DEF_DWELL    : default settle interval in clock cycles
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DWELL = 2;

    // Dwell counter is 4 bits wide, enough for the largest allowed dwell (15).
    localparam int CNT_W     = 4;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_if
// Bundles every non-clock signal of the scan controller.
//   Control inputs : en, ch_mask
//   Mux side       : s0, s1 (selects out), y_in (mux output fed back)
//   Stream side    : data_out, ch_out, valid_out (out), ready_in (in)
//   Status         : busy
// Modports:
//   master : the scan controller
//   slave  : the environment (mux + consumer + control source)
// -----------------------------------------------------------------------------
interface mux_scan_if
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                en;
    logic [NUM_CH-1:0]   ch_mask;
    logic [WIDTH-1:0]    y_in;
    logic                s0;
    logic                s1;
    logic [WIDTH-1:0]    data_out;
    logic [CH_W-1:0]     ch_out;
    logic                valid_out;
    logic                ready_in;
    logic                busy;

    modport master (
        input  en,
        input  ch_mask,
        input  y_in,
        input  ready_in,
        output s0,
        output s1,
        output data_out,
        output ch_out,
        output valid_out,
        output busy
    );

    modport slave (
        output en,
        output ch_mask,
        output y_in,
        output ready_in,
        input  s0,
        input  s1,
        input  data_out,
        input  ch_out,
        input  valid_out,
        input  busy
    );

endinterface : mux_scan_if

// File: rtl/mux4to1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux4to1
// Plain 4:1 data multiplexer that the scan controller drives.
//   i0..i3 : data inputs
//   s1, s0 : select, {s1,s0} = k routes ik to y
//   y      : selected data
// -----------------------------------------------------------------------------
module mux4to1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = i0;
        case ({s1, s0})
            2'b00:   y = i0;
            2'b01:   y = i1;
            2'b10:   y = i2;
            default: y = i3;
        endcase
    end

endmodule : mux4to1

// File: rtl/rr_next_ch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rr_next_ch
// Combinational round-robin picker over the four mux channels.
//   last : channel selected most recently
//   mask : per-channel enable, bit k enables channel k
//   next : first enabled channel searching last+1, last+2, last+3, last
//   any  : at least one channel is enabled (next is meaningful)
// -----------------------------------------------------------------------------
module rr_next_ch
    import mux_scan_pkg::*;
(
    input  logic [CH_W-1:0]   last,
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   next,
    output logic              any
);

    logic [CH_W-1:0] cand;

    // The offset NUM_CH wraps back onto 'last' itself, so a lone enabled
    // channel is picked again and the scan repeats on it.
    always_comb begin
        next = last;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = last + CH_W'(k);
            if (!any && mask[cand]) begin
                next = cand;
                any  = 1'b1;
            end
        end
    end

endmodule : rr_next_ch

// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Scans a 4:1 mux round-robin over the enabled channels. After each select
// change it waits DWELL cycles for the mux output to settle, captures y_in
// and offers it downstream with a valid/ready handshake, tagged with the
// channel it came from.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : mux_scan_if.master
//           en, ch_mask           scan enable and per-channel enable
//           s1, s0 / y_in         mux selects out, mux output back in
//           data_out, ch_out,
//           valid_out / ready_in  captured sample stream
//           busy                  high while in SETTLE or HOLD
// Parameters:
//   WIDTH : data width of y_in / data_out
//   DWELL : settle cycles between a select change and the capture (1..15)
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DWELL = DEF_DWELL
) (
    input  logic         clk,
    input  logic         rst,
    mux_scan_if.master   bus
);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL);

    scan_state_t       state_q;
    logic [CH_W-1:0]   sel_q;
    logic [CH_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  data_q;
    logic [CH_W-1:0]   ch_q;
    logic              valid_q;

    logic [CH_W-1:0]   nxt_ch;
    logic              any_ch;

    rr_next_ch u_rr_next_ch (
        .last (ptr_q),
        .mask (bus.ch_mask),
        .next (nxt_ch),
        .any  (any_ch)
    );

    // Single-process FSM. The selects only move on the edge that leaves
    // IDLE or completes a HOLD transfer, so they are frozen throughout
    // SETTLE and HOLD. The pointer resets to 3 so the first pick is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en && any_ch) begin
                        sel_q   <= nxt_ch;
                        ptr_q   <= nxt_ch;
                        cnt_q   <= DWELL_LD;
                        state_q <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    // An abort leaves the pointer on the aborted channel,
                    // so a restart moves on to the one after it.
                    if (!bus.en) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(1)) begin
                        data_q  <= bus.y_in;
                        ch_q    <= sel_q;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    // The held sample is never withdrawn; en only decides
                    // whether scanning resumes once it has been taken.
                    if (bus.ready_in) begin
                        valid_q <= 1'b0;
                        if (bus.en && any_ch) begin
                            sel_q   <= nxt_ch;
                            ptr_q   <= nxt_ch;
                            cnt_q   <= DWELL_LD;
                            state_q <= ST_SETTLE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s0        = sel_q[0];
    assign bus.s1        = sel_q[1];
    assign bus.data_out  = data_q;
    assign bus.ch_out    = ch_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Two controllers each drive a 4:1 mux holding i0=1, i1=2, i2=2, i3=3:
// dutA has DWELL=2, dutB has DWELL=1. Expected samples are queued as
// stimulus is applied and popped whenever a transfer is seen.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux_scan_if #(.WIDTH(4)) busA ();
    mux_scan_if #(.WIDTH(4)) busB ();

    mux4to1 #(.WIDTH(4)) muxA (
        .i0 (4'd1), .i1 (4'd2), .i2 (4'd2), .i3 (4'd3),
        .s0 (busA.s0), .s1 (busA.s1), .y (busA.y_in)
    );

    mux4to1 #(.WIDTH(4)) muxB (
        .i0 (4'd1), .i1 (4'd2), .i2 (4'd2), .i3 (4'd3),
        .s0 (busB.s0), .s1 (busB.s1), .y (busB.y_in)
    );

    mux_scan_ctrl #(.WIDTH(4), .DWELL(2)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.master)
    );

    mux_scan_ctrl #(.WIDTH(4), .DWELL(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.master)
    );

    typedef struct {
        logic [1:0] ch;
        logic [3:0] data;
    } sample_t;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] ch;
        logic [3:0] data;
    } vec_t;

    sample_t expA[$];
    sample_t expB[$];
    vec_t    vecs[9];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [3:0] m, input logic r);
        busA.en       = e;
        busA.ch_mask  = m;
        busA.ready_in = r;
    endtask

    task automatic pushA(input logic [1:0] ch, input logic [3:0] data);
        sample_t s;
        s.ch   = ch;
        s.data = data;
        expA.push_back(s);
    endtask

    task automatic pushB(input logic [1:0] ch, input logic [3:0] data);
        sample_t s;
        s.ch   = ch;
        s.data = data;
        expB.push_back(s);
    endtask

    // Transfers are seen half a cycle before the edge that completes them.
    always @(negedge clk) begin : monA
        sample_t s;
        if (!rst && busA.valid_out && busA.ready_in) begin
            if (expA.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreA_unexpected: got ch=%0d data=%0h, expected no sample",
                         busA.ch_out, busA.data_out);
            end else begin
                s = expA.pop_front();
                checkOutput("scoreA_ch", 32'(busA.ch_out), 32'(s.ch));
                checkOutput("scoreA_data", 32'(busA.data_out), 32'(s.data));
            end
        end
    end

    always @(negedge clk) begin : monB
        sample_t s;
        if (!rst && busB.valid_out && busB.ready_in) begin
            if (expB.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreB_unexpected: got ch=%0d data=%0h, expected no sample",
                         busB.ch_out, busB.data_out);
            end else begin
                s = expB.pop_front();
                checkOutput("scoreB_ch", 32'(busB.ch_out), 32'(s.ch));
                checkOutput("scoreB_data", 32'(busB.data_out), 32'(s.data));
            end
        end
    end

    // Runs dutA with ready high until nsamp samples have appeared, expecting
    // valid on every third cycle, then drops en so the last transfer idles.
    task automatic runScan(input int nsamp, input string tag);
        int seen;
        seen = 0;
        for (int cyc = 1; cyc <= 60 && seen < nsamp; cyc++) begin
            tick();
            checkOutput({tag, "_valid"}, 32'(busA.valid_out), 32'((cyc % 3) == 0));
            if (busA.valid_out) begin
                seen++;
                if (seen == nsamp) busA.en = 1'b0;
            end
        end
        checkOutput({tag, "_count"}, 32'(seen), 32'(nsamp));
        tick();
        checkOutput({tag, "_idle_busy"}, 32'(busA.busy), 32'd0);
        checkOutput({tag, "_idle_valid"}, 32'(busA.valid_out), 32'd0);
    endtask

    initial begin
        int grpStart;
        int seenB;
        logic [1:0] selHeld;

        vecs[0] = '{4'b1111, 2'd0, 4'd1};
        vecs[1] = '{4'b1111, 2'd1, 4'd2};
        vecs[2] = '{4'b1111, 2'd2, 4'd2};
        vecs[3] = '{4'b1111, 2'd3, 4'd3};
        vecs[4] = '{4'b1111, 2'd0, 4'd1};
        vecs[5] = '{4'b1010, 2'd1, 4'd2};
        vecs[6] = '{4'b1010, 2'd3, 4'd3};
        vecs[7] = '{4'b1010, 2'd1, 4'd2};
        vecs[8] = '{4'b1010, 2'd3, 4'd3};

        busB.en       = 1'b0;
        busB.ch_mask  = 4'b1111;
        busB.ready_in = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b1);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_valid", 32'(busA.valid_out), 32'd0);
        checkOutput("rst_data", 32'(busA.data_out), 32'd0);
        checkOutput("rst_ch", 32'(busA.ch_out), 32'd0);
        checkOutput("rst_sel", 32'({busA.s1, busA.s0}), 32'd0);
        checkOutput("rst_busy", 32'(busA.busy), 32'd0);
        rst = 1'b0;

        // Full scan and sparse-mask scan from the table
        grpStart = 0;
        for (int i = 0; i < 9; i++) begin
            pushA(vecs[i].ch, vecs[i].data);
            if (i == 8 || vecs[i+1].mask != vecs[i].mask) begin
                applyStimulus(1'b1, vecs[i].mask, 1'b1);
                runScan(i - grpStart + 1, $sformatf("scan_m%b", vecs[i].mask));
                grpStart = i + 1;
            end
        end

        // Backpressure: last channel was 3, so the scan restarts at 0
        pushA(2'd0, 4'd1);
        pushA(2'd1, 4'd2);
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("bp_pre_valid", 32'(busA.valid_out), 32'd0);
        tick();
        checkOutput("bp_first_valid", 32'(busA.valid_out), 32'd1);
        busA.ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("bp_hold_valid", 32'(busA.valid_out), 32'd1);
            checkOutput("bp_hold_data", 32'(busA.data_out), 32'd1);
            checkOutput("bp_hold_ch", 32'(busA.ch_out), 32'd0);
            checkOutput("bp_hold_sel", 32'({busA.s1, busA.s0}), 32'd0);
        end
        busA.ready_in = 1'b1;
        tick();
        checkOutput("bp_release_sel", 32'({busA.s1, busA.s0}), 32'd1);
        checkOutput("bp_release_valid", 32'(busA.valid_out), 32'd0);
        tick();
        tick();
        checkOutput("bp_second_valid", 32'(busA.valid_out), 32'd1);
        busA.en = 1'b0;
        tick();
        checkOutput("bp_idle_busy", 32'(busA.busy), 32'd0);

        // Abort one cycle into SETTLE (last channel 1, so channel 2 is picked)
        applyStimulus(1'b1, 4'b1111, 1'b1);
        tick();
        checkOutput("abort_busy", 32'(busA.busy), 32'd1);
        checkOutput("abort_sel", 32'({busA.s1, busA.s0}), 32'd2);
        busA.en = 1'b0;
        tick();
        checkOutput("abort_idle_busy", 32'(busA.busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("abort_no_valid", 32'(busA.valid_out), 32'd0);
        end

        // Empty mask with en high never leaves IDLE
        applyStimulus(1'b1, 4'b0000, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("empty_busy", 32'(busA.busy), 32'd0);
            checkOutput("empty_valid", 32'(busA.valid_out), 32'd0);
        end
        selHeld = {busA.s1, busA.s0};
        checkOutput("empty_sel_held", 32'(selHeld), 32'd2);

        // Reset while a sample is held (aborted channel 2, so channel 3 next)
        applyStimulus(1'b1, 4'b1111, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("rsthold_valid", 32'(busA.valid_out), 32'd1);
        checkOutput("rsthold_ch", 32'(busA.ch_out), 32'd3);
        checkOutput("rsthold_data", 32'(busA.data_out), 32'd3);
        rst = 1'b1;
        tick();
        checkOutput("rsthold_after_valid", 32'(busA.valid_out), 32'd0);
        checkOutput("rsthold_after_data", 32'(busA.data_out), 32'd0);
        checkOutput("rsthold_after_sel", 32'({busA.s1, busA.s0}), 32'd0);
        checkOutput("rsthold_after_busy", 32'(busA.busy), 32'd0);
        rst = 1'b0;
        busA.ready_in = 1'b1;
        pushA(2'd0, 4'd1);
        tick();
        tick();
        checkOutput("rstrun_pre_valid", 32'(busA.valid_out), 32'd0);
        tick();
        checkOutput("rstrun_valid", 32'(busA.valid_out), 32'd1);
        checkOutput("rstrun_ch", 32'(busA.ch_out), 32'd0);
        busA.en = 1'b0;
        tick();

        // DWELL=1 controller: one sample every two cycles
        pushB(2'd0, 4'd1);
        pushB(2'd1, 4'd2);
        pushB(2'd2, 4'd2);
        pushB(2'd3, 4'd3);
        busB.en = 1'b1;
        seenB = 0;
        for (int cyc = 1; cyc <= 40 && seenB < 4; cyc++) begin
            tick();
            checkOutput("d1_valid", 32'(busB.valid_out), 32'((cyc % 2) == 0));
            if (busB.valid_out) begin
                seenB++;
                if (seenB == 4) busB.en = 1'b0;
            end
        end
        checkOutput("d1_count", 32'(seenB), 32'd4);
        tick();
        checkOutput("d1_idle_busy", 32'(busB.busy), 32'd0);

        tick();
        checkOutput("scoreA_drained", 32'(expA.size()), 32'd0);
        checkOutput("scoreB_drained", 32'(expB.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
